// File: rtl/maze_move_sequencer_pkg.sv
// Shared MazeSolver definitions: move codes, motor encodings, sequencer states.
// The explorer FSM imports the same move constants.
package maze_pkg;

    localparam logic [2:0] STOP    = 3'b000;
    localparam logic [2:0] FORWARD = 3'b001;
    localparam logic [2:0] LEFT    = 3'b010;
    localparam logic [2:0] RIGHT   = 3'b011;
    localparam logic [2:0] U_TURN  = 3'b100;

    localparam logic [1:0] MOT_OFF = 2'b00;
    localparam logic [1:0] MOT_FWD = 2'b01;
    localparam logic [1:0] MOT_REV = 2'b10;

    typedef enum logic [2:0] {
        S_BOOT_SENSE,
        S_IDLE,
        S_TURN,
        S_DRIVE,
        S_SENSE,
        S_REPORT,
        S_HALT,
        S_ERR
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/maze_move_sequencer_if.sv
// Explorer <-> sequencer <-> motor/sensor bundle.
// Optional counters exist only with MAZE_SEQ_DEADEND_CNT_EN defined.
interface maze_move_sequencer_if;

    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] motor_l;
    logic [1:0] motor_r;
    logic       sense_req;
    logic       sense_ack;
    logic [2:0] sense_walls;
    logic [2:0] walls;
    logic       walls_valid;
    logic       busy;
    logic       done;
    logic       timeout_err;
`ifdef MAZE_SEQ_DEADEND_CNT_EN
    logic [3:0] deadend_cnt;
    logic [7:0] steps_cnt;
`endif

    modport master (
        output cmd, cmd_valid, sense_ack, sense_walls,
        input  cmd_ready, motor_l, motor_r, sense_req,
        input  walls, walls_valid, busy, done, timeout_err
`ifdef MAZE_SEQ_DEADEND_CNT_EN
        , input deadend_cnt, steps_cnt
`endif
    );

    modport slave (
        input  cmd, cmd_valid, sense_ack, sense_walls,
        output cmd_ready, motor_l, motor_r, sense_req,
        output walls, walls_valid, busy, done, timeout_err
`ifdef MAZE_SEQ_DEADEND_CNT_EN
        , output deadend_cnt, steps_cnt
`endif
    );

endinterface

// File: rtl/maze_phase_timer.sv
// Loadable down-counter; expires when the count reaches 1, idles at 0.
// Shared by the turn/drive phases and the sense timeout.
module maze_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         expire_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == W'(1));
    assign zero_o   = (cnt_q == '0);

endmodule

// File: rtl/maze_move_sequencer.sv
// Move sequencer: times turn/drive phases, samples walls, reports to explorer.
// Define MAZE_SEQ_DEADEND_CNT_EN to add the dead-end and step counters.
module maze_move_sequencer
    import maze_pkg::*;
#(
    parameter int TURN_CYCLES   = 4,
    parameter int FWD_CYCLES    = 8,
    parameter int SENSE_TIMEOUT = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    maze_move_sequencer_if.slave  bus
);

    localparam int CNT_MAX = max3(2 * TURN_CYCLES, FWD_CYCLES, SENSE_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX) + 1;

    seq_state_e state_q, state_d;
    logic [2:0] cmd_q, cmd_d;
    logic [2:0] walls_q, walls_d;

    logic          t_load, t_en, t_exp, t_zero;
    logic [CW-1:0] t_val;
    logic          accept;

    logic       rdy_q, rdy_d;
    logic [1:0] ml_q, ml_d, mr_q, mr_d;
    logic       req_q, req_d;
    logic       wv_q, wv_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    maze_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (t_load),
        .val_i    (t_val),
        .en_i     (t_en),
        .expire_o (t_exp),
        .zero_o   (t_zero)
    );

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        walls_d = walls_q;
        t_load  = 1'b0;
        t_val   = '0;
        t_en    = 1'b0;
        unique case (state_q)
            S_BOOT_SENSE, S_SENSE: begin
                // ack beats a coinciding timeout; boot arms its timer on first clock
                if (bus.sense_ack) begin
                    walls_d = bus.sense_walls;
                    state_d = S_REPORT;
                end else if (t_exp) begin
                    state_d = S_ERR;
                end else if (t_zero) begin
                    t_load = 1'b1;
                    t_val  = CW'(SENSE_TIMEOUT);
                end else begin
                    t_en = 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    cmd_d  = bus.cmd;
                    t_load = 1'b1;
                    case (bus.cmd)
                        FORWARD: begin
                            state_d = S_DRIVE;
                            t_val   = CW'(FWD_CYCLES);
                        end
                        LEFT, RIGHT: begin
                            state_d = S_TURN;
                            t_val   = CW'(TURN_CYCLES);
                        end
                        U_TURN: begin
                            state_d = S_TURN;
                            t_val   = CW'(2 * TURN_CYCLES);
                        end
                        STOP: begin
                            state_d = S_HALT;
                            t_load  = 1'b0;
                        end
                        default: begin
                            state_d = S_SENSE;
                            t_val   = CW'(SENSE_TIMEOUT);
                        end
                    endcase
                end
            end
            S_TURN: begin
                if (t_exp) begin
                    state_d = S_DRIVE;
                    t_load  = 1'b1;
                    t_val   = CW'(FWD_CYCLES);
                end else begin
                    t_en = 1'b1;
                end
            end
            S_DRIVE: begin
                if (t_exp) begin
                    state_d = S_SENSE;
                    t_load  = 1'b1;
                    t_val   = CW'(SENSE_TIMEOUT);
                end else begin
                    t_en = 1'b1;
                end
            end
            S_REPORT: state_d = S_IDLE;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_ERR;
        endcase
    end

    // Outputs are registered from the next state so reset holds them all at 0
    always_comb begin
        rdy_d  = (state_d == S_IDLE);
        ml_d   = MOT_OFF;
        mr_d   = MOT_OFF;
        req_d  = (state_d == S_SENSE) || (state_d == S_BOOT_SENSE);
        wv_d   = (state_d == S_REPORT);
        busy_d = !((state_d == S_IDLE) || (state_d == S_HALT) ||
                   (state_d == S_ERR));
        done_d = (state_d == S_HALT);
        err_d  = (state_d == S_ERR);
        if (state_d == S_TURN) begin
            ml_d = (cmd_d == RIGHT) ? MOT_FWD : MOT_REV;
            mr_d = (cmd_d == RIGHT) ? MOT_REV : MOT_FWD;
        end else if (state_d == S_DRIVE) begin
            ml_d = MOT_FWD;
            mr_d = MOT_FWD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT_SENSE;
            cmd_q   <= STOP;
            walls_q <= '0;
            rdy_q   <= 1'b0;
            ml_q    <= MOT_OFF;
            mr_q    <= MOT_OFF;
            req_q   <= 1'b0;
            wv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            walls_q <= walls_d;
            rdy_q   <= rdy_d;
            ml_q    <= ml_d;
            mr_q    <= mr_d;
            req_q   <= req_d;
            wv_q    <= wv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready   = rdy_q;
    assign bus.motor_l     = ml_q;
    assign bus.motor_r     = mr_q;
    assign bus.sense_req   = req_q;
    assign bus.walls       = walls_q;
    assign bus.walls_valid = wv_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;

`ifdef MAZE_SEQ_DEADEND_CNT_EN
    logic [3:0] dead_q, dead_d;
    logic [7:0] steps_q, steps_d;

    always_comb begin
        dead_d  = dead_q;
        steps_d = steps_q;
        if (accept && (bus.cmd == U_TURN) && (dead_q != 4'hF)) begin
            dead_d = dead_q + 4'd1;
        end
        if (accept && (bus.cmd inside {FORWARD, LEFT, RIGHT, U_TURN}) &&
            (steps_q != 8'hFF)) begin
            steps_d = steps_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_q  <= '0;
            steps_q <= '0;
        end else begin
            dead_q  <= dead_d;
            steps_q <= steps_d;
        end
    end

    assign bus.deadend_cnt = dead_q;
    assign bus.steps_cnt   = steps_q;
`endif

endmodule
